// File: rtl/alu_op_issue_if.sv
// Handshake and operand bus between the instruction source, the register file
// read port and the ALU operand consumer.
interface alu_op_issue_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [31:0]      rs1_data;
  logic [31:0]      rs2_data;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      opA;
  logic [31:0]      opB;
  logic [3:0]       aluOutSel;
  logic [4:0]       rd_addr;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  // The issue block masters the operand bus.
  modport master (
    input  instr_valid, instr, rs1_data, rs2_data, op_ready,
    output instr_ready, rs1_addr, rs2_addr, op_valid, opA, opB, aluOutSel,
           rd_addr, illegal, illegal_cnt
  );

  modport slave (
    output instr_valid, instr, rs1_data, rs2_data, op_ready,
    input  instr_ready, rs1_addr, rs2_addr, op_valid, opA, opB, aluOutSel,
           rd_addr, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_op_issue.sv
// Decodes RV32I OP / OP-IMM / LUI words into ALU operands and queues them in a
// two-entry registered buffer whose head drives the downstream ALU.
module alu_op_issue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  alu_op_issue_if.master iss
);

  typedef enum logic [3:0] {
    SEL_ADD  = 4'b0000, SEL_SUB  = 4'b0001, SEL_XOR = 4'b0010, SEL_OR  = 4'b0011,
    SEL_AND  = 4'b0100, SEL_SLT  = 4'b0101, SEL_SLTU = 4'b0110, SEL_SLL = 4'b0111,
    SEL_SRL  = 4'b1000, SEL_SRA  = 4'b1001
  } sel_e;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  sel;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] F7_ZERO   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  function automatic logic [3:0] base_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  return SEL_ADD;
      3'b001:  return SEL_SLL;
      3'b010:  return SEL_SLT;
      3'b011:  return SEL_SLTU;
      3'b100:  return SEL_XOR;
      3'b101:  return SEL_SRL;
      3'b110:  return SEL_OR;
      default: return SEL_AND;
    endcase
  endfunction

  logic [1:0]       count_q, count_d;
  entry_t           head_q, head_d, tail_q, tail_d;
  logic             ready_q;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  entry_t           dec;
  logic             legal, push, pop;

  wire [6:0] opcode = iss.instr[6:0];
  wire [2:0] f3     = iss.instr[14:12];
  wire [6:0] f7     = iss.instr[31:25];

  assign iss.rs1_addr = iss.instr[19:15];
  assign iss.rs2_addr = iss.instr[24:20];

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op_a = iss.rs1_data;
        dec.op_b = iss.rs2_data;
        if (f7 == F7_ZERO) begin
          legal   = 1'b1;
          dec.sel = base_sel(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          legal   = 1'b1;
          dec.sel = SEL_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          legal   = 1'b1;
          dec.sel = SEL_SRA;
        end
      end
      OPC_OPIMM: begin
        dec.op_a = iss.rs1_data;
        if (f3 == 3'b001 || f3 == 3'b101) begin
          // Shift-immediates carry a shamt and reuse the OP funct7 rules; no SUBI exists.
          dec.op_b = {27'b0, iss.instr[24:20]};
          if (f7 == F7_ZERO) begin
            legal   = 1'b1;
            dec.sel = base_sel(f3);
          end else if (f7 == F7_ALT && f3 == 3'b101) begin
            legal   = 1'b1;
            dec.sel = SEL_SRA;
          end
        end else begin
          legal    = 1'b1;
          dec.op_b = {{20{iss.instr[31]}}, iss.instr[31:20]};
          dec.sel  = base_sel(f3);
        end
      end
      OPC_LUI: begin
        legal    = 1'b1;
        dec.op_b = {iss.instr[31:12], 12'b0};
        dec.sel  = SEL_ADD;
      end
      default: legal = 1'b0;
    endcase
    if (legal) begin
      dec.rd = iss.instr[11:7];
    end else begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // ready_q holds instr_ready low during reset and until the first edge after release.
  assign iss.instr_ready = ready_q && (count_q != 2'(DEPTH));
  assign iss.op_valid    = (count_q != 2'd0);
  assign push            = iss.instr_valid && iss.instr_ready;
  assign pop             = iss.op_valid && iss.op_ready;

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    ill_cnt_d = ill_cnt_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = dec;
        else                 tail_d = dec;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Push needs count < 2 and pop needs count > 0, so count is 1 and the new word becomes head.
      2'b11:   head_d = dec;
      default: ;
    endcase
    if (push && dec.illegal && ill_cnt_q != '1) ill_cnt_d = ill_cnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: both buffer entries are reset because the head register drives the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      ready_q   <= 1'b0;
      ill_cnt_q <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      ready_q   <= 1'b1;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign iss.opA         = head_q.op_a;
  assign iss.opB         = head_q.op_b;
  assign iss.aluOutSel   = head_q.sel;
  assign iss.rd_addr     = head_q.rd;
  assign iss.illegal     = head_q.illegal;
  assign iss.illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue: decode vectors, backpressure, streaming,
// illegal words and asynchronous reset with buffered entries.
module tb_alu_op_issue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_op_issue_if #(.CNT_W(16)) bus ();

  alu_op_issue #(.DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iss   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] sel, input logic [4:0] rd, input logic ill);
    check({tag, ".valid"},   32'(bus.op_valid),  32'd1);
    check({tag, ".opA"},     bus.opA,            a);
    check({tag, ".opB"},     bus.opB,            b);
    check({tag, ".sel"},     32'(bus.aluOutSel), 32'(sel));
    check({tag, ".rd"},      32'(bus.rd_addr),   32'(rd));
    check({tag, ".illegal"}, 32'(bus.illegal),   32'(ill));
  endtask

  function automatic logic [31:0] add_word(input logic [4:0] rd);
    return {7'b0, 5'd2, 5'd1, 3'b000, rd, 7'b0110011};
  endfunction

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 32'h0;
    bus.rs1_data    = 32'h0;
    bus.rs2_data    = 32'h0;
    bus.op_ready    = 1'b0;

    // Reset state
    #12;
    check("rst.op_valid",    32'(bus.op_valid),    32'd0);
    check("rst.instr_ready", 32'(bus.instr_ready), 32'd0);
    check("rst.opA",         bus.opA,              32'd0);
    check("rst.opB",         bus.opB,              32'd0);
    check("rst.sel",         32'(bus.aluOutSel),   32'd0);
    check("rst.rd",          32'(bus.rd_addr),     32'd0);
    check("rst.illegal",     32'(bus.illegal),     32'd0);
    check("rst.ill_cnt",     32'(bus.illegal_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.ready_before_edge", 32'(bus.instr_ready), 32'd0);
    tick();
    check("rel.ready_after_edge", 32'(bus.instr_ready), 32'd1);

    // ADD x3,x1,x2
    bus.instr = 32'h002081B3; bus.rs1_data = 32'd5; bus.rs2_data = 32'd7;
    bus.instr_valid = 1'b1; bus.op_ready = 1'b1;
    #1;
    check("add.rs1_addr", 32'(bus.rs1_addr), 32'd1);
    check("add.rs2_addr", 32'(bus.rs2_addr), 32'd2);
    tick();
    bus.instr_valid = 1'b0;
    check_head("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b0);
    tick();
    check("add.drained", 32'(bus.op_valid), 32'd0);

    // ADDI x1,x0,-1 then SRAI x1,x1,4 back to back
    bus.instr = 32'hFFF00093; bus.rs1_data = 32'd0; bus.rs2_data = 32'hDEADBEEF;
    bus.instr_valid = 1'b1;
    tick();
    check_head("addi", 32'd0, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b0);
    bus.instr = 32'h4040D093; bus.rs1_data = 32'h80000000;
    tick();
    bus.instr_valid = 1'b0;
    check_head("srai", 32'h80000000, 32'd4, 4'b1001, 5'd1, 1'b0);
    tick();

    // ORI x6,x1,0xF0 and LUI x10,0x12345
    bus.instr = 32'h0F00E313; bus.rs1_data = 32'h0000000F; bus.instr_valid = 1'b1;
    tick();
    check_head("ori", 32'h0000000F, 32'h000000F0, 4'b0011, 5'd6, 1'b0);
    bus.instr = 32'h12345537; bus.rs1_data = 32'h11111111;
    tick();
    bus.instr_valid = 1'b0;
    check_head("lui", 32'd0, 32'h12345000, 4'b0000, 5'd10, 1'b0);
    tick();

    // Backpressure: three words offered, two accepted, FIFO order kept
    bus.op_ready = 1'b0; bus.instr_valid = 1'b1;
    bus.instr = 32'h002081B3; bus.rs1_data = 32'd10; bus.rs2_data = 32'd20;
    #1 check("bp.ready1", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr = 32'h40208233; bus.rs1_data = 32'd11; bus.rs2_data = 32'd21;
    check("bp.ready2", 32'(bus.instr_ready), 32'd1);
    tick();
    bus.instr = 32'h0020C2B3; bus.rs1_data = 32'd12; bus.rs2_data = 32'd22;
    check("bp.ready3", 32'(bus.instr_ready), 32'd0);
    tick();
    bus.instr_valid = 1'b0;
    check_head("bp.w1_stable", 32'd10, 32'd20, 4'b0000, 5'd3, 1'b0);
    bus.op_ready = 1'b1;
    tick();
    check_head("bp.w2", 32'd11, 32'd21, 4'b0001, 5'd4, 1'b0);
    tick();
    check("bp.empty", 32'(bus.op_valid), 32'd0);

    // Streaming at count 1: push and pop every cycle
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 21; i++) begin
      bus.instr    = add_word(5'(i));
      bus.rs1_data = 32'(100 + i);
      bus.rs2_data = 32'(200 + i);
      tick();
      check($sformatf("stream%0d.valid", i), 32'(bus.op_valid), 32'd1);
      check($sformatf("stream%0d.opA", i),   bus.opA,            32'(100 + i));
      check($sformatf("stream%0d.rd", i),    32'(bus.rd_addr),   32'(i));
    end
    bus.instr_valid = 1'b0;
    tick();
    check("stream.drained", 32'(bus.op_valid), 32'd0);

    // Illegal words are queued with zeroed fields and counted
    bus.instr = 32'h0000007F; bus.rs1_data = 32'h55555555; bus.rs2_data = 32'hAAAAAAAA;
    bus.instr_valid = 1'b1;
    tick();
    check_head("ill1", 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1);
    check("ill1.cnt", 32'(bus.illegal_cnt), 32'd1);
    bus.instr = 32'h4020C1B3;
    tick();
    check_head("ill2", 32'd0, 32'd0, 4'b0000, 5'd0, 1'b1);
    check("ill2.cnt", 32'(bus.illegal_cnt), 32'd2);
    bus.instr = 32'h40209093;  // SLLI with funct7 0100000
    tick();
    bus.instr_valid = 1'b0;
    check("ill3.illegal", 32'(bus.illegal),     32'd1);
    check("ill3.cnt",     32'(bus.illegal_cnt), 32'd3);
    tick();

    // Asynchronous reset with two buffered entries
    bus.op_ready = 1'b0; bus.instr_valid = 1'b1;
    bus.instr = 32'h002081B3; bus.rs1_data = 32'd1; bus.rs2_data = 32'd2;
    tick();
    tick();
    bus.instr_valid = 1'b0;
    check("ar.full", 32'(bus.instr_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar.op_valid",    32'(bus.op_valid),    32'd0);
    check("ar.instr_ready", 32'(bus.instr_ready), 32'd0);
    check("ar.ill_cnt",     32'(bus.illegal_cnt), 32'd0);
    check("ar.opA",         bus.opA,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.op_ready = 1'b1;
    tick();
    check("ar.ready_after", 32'(bus.instr_ready), 32'd1);
    check("ar.no_replay1",  32'(bus.op_valid),    32'd0);
    tick();
    check("ar.no_replay2",  32'(bus.op_valid),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
